// File: rtl/counter_pkg.sv
// Shared types for the counter_mod_nbit timer/counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_e;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step per PRESCALE enable-high cycles.
// Instantiated by counter_mod_nbit only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clr,
  output logic step
);

  // PRESCALE=1 keeps a 1-bit register pinned at 0, so step degenerates to enable.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  assign step = enable && (pre == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)  pre <= '0;
    else if (enable) pre <= step ? '0 : pre + PW'(1);
  end

endmodule

// File: rtl/counter_mod_nbit.sv
// Parametrised up/down modulo counter with wrap, saturate and one-shot modes.
// Optional enable prescaler under macro COUNTER_PRESCALE_EN.
module counter_mod_nbit
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter int          PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod_nbit: WIDTH must be 2..32");
  end
  if (MAX_VAL < 1 || (WIDTH < 32 && MAX_VAL > (2**WIDTH) - 1)) begin : g_bad_max
    $error("counter_mod_nbit: MAX_VAL out of range");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("counter_mod_nbit: PRESCALE must be >= 1");
  end

  logic step;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clr    (clear | load),
    .step   (step)
  );
`else
  assign step = enable;
`endif

  // Reserved encoding 3 decodes to WRAP.
  cnt_mode_e md;
  always_comb begin
    case (mode)
      2'd1:    md = CNT_SAT;
      2'd2:    md = CNT_ONESHOT;
      default: md = CNT_WRAP;
    endcase
  end

  logic             hit;
  logic [WIDTH-1:0] count_nxt;
  logic             run_nxt;

  assign hit = up ? (count == MAX_L) : (count == '0);
  assign tc  = step && hit && running && !clear && !load && !rst;

  always_comb begin
    count_nxt = count;
    // running only means anything in one-shot; elsewhere it is forced back to 1.
    run_nxt   = (md != CNT_ONESHOT) ? 1'b1 : running;
    if (step && !(md == CNT_ONESHOT && !running)) begin
      if (hit) begin
        case (md)
          CNT_WRAP:    count_nxt = up ? '0 : MAX_L;
          CNT_ONESHOT: run_nxt   = 1'b0;
          default:     count_nxt = count;
        endcase
      end else begin
        count_nxt = up ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b1;
    end else if (clear) begin
      count   <= '0;
      running <= 1'b1;
    end else if (load) begin
      count   <= (load_value > MAX_L) ? MAX_L : load_value;
      running <= 1'b1;
    end else begin
      count   <= count_nxt;
      running <= run_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod_nbit.sv
// Bench for counter_mod_nbit (WIDTH=4, MAX_VAL=9): directed vector table,
// prescaler sequence when COUNTER_PRESCALE_EN is defined, then random vs. model.
module tb_counter_mod_nbit;

  localparam int W  = 4;
  localparam int MV = 9;
  localparam int PS = 3;

  logic         clk = 1'b0;
  logic         rst, enable, up, clear, load;
  logic [1:0]   mode;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         tc, running;

  counter_mod_nbit #(.WIDTH(W), .MAX_VAL(MV), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .mode(mode),
    .clear(clear), .load(load), .load_value(load_value),
    .count(count), .tc(tc), .running(running)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_cnt = 0;
  int m_pre = 0;
  bit m_run = 1'b1;

  // values sampled before each edge
  logic [31:0] s_cnt, s_tc, s_run;
  logic [31:0] e_cnt, e_tc, e_run;

  typedef struct {
    string    nm;
    bit       r, e, u;
    bit [1:0] md;
    bit       c, l;
    int       lv;
    int       cnt;
    bit       t;
    bit       run;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_step();
`ifdef COUNTER_PRESCALE_EN
    return enable && (m_pre == PS - 1);
`else
    return enable;
`endif
  endfunction

  function automatic bit m_hit();
    return up ? (m_cnt == MV) : (m_cnt == 0);
  endfunction

  function automatic bit m_tc();
    return m_step() && m_hit() && m_run && !clear && !load && !rst;
  endfunction

  // Rules applied directly: priority rst > clear > load > step, then by mode.
  task automatic m_adv();
    bit st, h;
    int md;
    st = m_step();
    h  = m_hit();
    md = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
    if (rst || clear) begin
      m_cnt = 0; m_run = 1'b1; m_pre = 0;
    end else if (load) begin
      m_cnt = (int'(load_value) > MV) ? MV : int'(load_value);
      m_run = 1'b1; m_pre = 0;
    end else begin
      if (enable) m_pre = (m_pre == PS - 1) ? 0 : m_pre + 1;
      if (st && !(md == 2 && !m_run)) begin
        if (!h)           m_cnt = up ? m_cnt + 1 : m_cnt - 1;
        else if (md == 0) m_cnt = up ? 0 : MV;
        else if (md == 2) m_run = 1'b0;
      end
      if (md != 2) m_run = 1'b1;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit u, input bit [1:0] md,
                       input bit c, input bit l, input int lv);
    rst = r; enable = e; up = u; mode = md; clear = c; load = l;
    load_value = W'(lv);
    #2;
    s_cnt = 32'(count); s_tc = 32'(tc); s_run = 32'(running);
    e_cnt = 32'(m_cnt); e_tc = 32'(m_tc()); e_run = 32'(m_run);
    @(posedge clk);
    m_adv();
    @(negedge clk);
  endtask

  task automatic add(input string nm, input bit r, input bit e, input bit u, input bit [1:0] md,
                     input bit c, input bit l, input int lv, input int cnt, input bit t, input bit run);
    vec_t v;
    v.nm = nm; v.r = r; v.e = e; v.u = u; v.md = md; v.c = c; v.l = l; v.lv = lv;
    v.cnt = cnt; v.t = t; v.run = run;
    tbl.push_back(v);
  endtask

  initial begin
    bit         r, e, u, c, l;
    bit [1:0]   md;
    int         lv;
    int         pexp[$];

    cycle(1, 0, 1, 0, 0, 0, 0);

`ifndef COUNTER_PRESCALE_EN
    // expected columns are the values observed in the cycle, before the edge
    add("rst", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++)
      add("wrap_up", 0, 1, 1, 0, 0, 0, 0, (i < 10) ? i : i - 10, i == 9, 1);
    add("wrap_end", 0, 0, 1, 0, 0, 0, 0, 2, 0, 1);
    add("rst2",     1, 0, 1, 0, 0, 0, 0, 2, 0, 1);
    add("dn0",      0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add("dn1",      0, 1, 0, 0, 0, 0, 0, 9, 0, 1);
    add("dn2",      0, 1, 0, 0, 0, 0, 0, 8, 0, 1);
    add("dn_end",   0, 0, 0, 0, 0, 0, 0, 7, 0, 1);
    add("sat_ld",   0, 0, 1, 1, 0, 1, 7, 7, 0, 1);
    for (int i = 0; i < 5; i++)
      add("sat", 0, 1, 1, 1, 0, 0, 0, (i < 2) ? 7 + i : 9, i >= 2, 1);
    add("sat_end",  0, 0, 1, 1, 0, 0, 0, 9, 0, 1);
    add("os_ld",    0, 0, 1, 2, 0, 1, 8, 9, 0, 1);
    add("os0",      0, 1, 1, 2, 0, 0, 0, 8, 0, 1);
    add("os1",      0, 1, 1, 2, 0, 0, 0, 9, 1, 1);
    add("os2",      0, 1, 1, 2, 0, 0, 0, 9, 0, 0);
    add("os3",      0, 1, 1, 2, 0, 0, 0, 9, 0, 0);
    add("os_clr",   0, 0, 1, 2, 1, 0, 0, 9, 0, 0);
    add("os_dn",    0, 1, 0, 2, 0, 0, 0, 0, 1, 1);
    add("os_leave", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add("wrap_run", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add("ld15",     0, 0, 1, 0, 0, 1, 15, 0, 0, 1);
    add("clr_ld_en",0, 1, 1, 0, 1, 1, 5, 9, 0, 1);
    add("clr_res",  0, 0, 1, 0, 0, 1, 5, 0, 0, 1);
    add("rst_all",  1, 1, 1, 2, 1, 1, 3, 5, 0, 1);
    add("rst_res",  0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add("m3_ld",    0, 0, 1, 3, 0, 1, 9, 0, 0, 1);
    add("m3",       0, 1, 1, 3, 0, 0, 0, 9, 1, 1);
    add("m3_res",   0, 0, 1, 3, 0, 0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].md, tbl[i].c, tbl[i].l, tbl[i].lv);
      chk({tbl[i].nm, "_count"},   s_cnt, 32'(tbl[i].cnt));
      chk({tbl[i].nm, "_tc"},      s_tc,  32'(tbl[i].t));
      chk({tbl[i].nm, "_running"}, s_run, 32'(tbl[i].run));
    end
`else
    // PRESCALE=3: steps on every third enable; gaps hold, load zeroes the prescaler
    cycle(1, 0, 1, 0, 0, 0, 0);
    pexp = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    foreach (pexp[i]) begin
      cycle(0, 1, 1, 0, 0, 0, 0);
      chk("pre_run_count", s_cnt, 32'(pexp[i]));
      chk("pre_run_tc",    s_tc,  32'd0);
    end
    cycle(0, 0, 1, 0, 0, 0, 0); chk("pre_9_count", s_cnt, 32'd3);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_gap_a", s_cnt, 32'd3);
    cycle(0, 0, 1, 0, 0, 0, 0); chk("pre_gap_b", s_cnt, 32'd3);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_gap_c", s_cnt, 32'd3);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_gap_d", s_cnt, 32'd3);
    cycle(0, 0, 1, 0, 0, 0, 0); chk("pre_gap_step", s_cnt, 32'd4);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_ld_a", s_cnt, 32'd4);
    cycle(0, 0, 1, 0, 0, 1, 0); chk("pre_ld_b", s_cnt, 32'd4);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_ld_c", s_cnt, 32'd0);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_ld_d", s_cnt, 32'd0);
    cycle(0, 1, 1, 0, 0, 0, 0); chk("pre_ld_e", s_cnt, 32'd0);
    cycle(0, 0, 1, 0, 0, 0, 0); chk("pre_ld_step", s_cnt, 32'd1);
`endif

    // random phase: sticky mode/direction so boundaries and one-shot get exercised
    md = 2'd0; u = 1'b1;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(99) < 2);
      c  = ($urandom_range(99) < 4);
      l  = ($urandom_range(99) < 5);
      e  = ($urandom_range(99) < 80);
      lv = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15));
      if ($urandom_range(99) < 5)  md = 2'($urandom_range(3));
      if ($urandom_range(99) < 10) u  = ~u;
      cycle(r, e, u, md, c, l, lv);
      chk("rand_count",   s_cnt, e_cnt);
      chk("rand_tc",      s_tc,  e_tc);
      chk("rand_running", s_run, e_run);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
